// File: rtl/ser.sv
// Word serializer: accepts one WIDTH_INPUT-bit word per handshake and emits it
// as WIDTH_OUTPUT-bit chunks, least-significant first, one chunk per cycle.
module ser #(
    parameter int unsigned WIDTH_INPUT  = 32,
    parameter int unsigned WIDTH_OUTPUT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Req,
    input  logic [WIDTH_INPUT-1:0]  I_Data,
    output logic                    O_Ready,
    input  logic                    I_Stall,
    output logic                    O_Valid,
    output logic [WIDTH_OUTPUT-1:0] O_Data,
    output logic                    O_Last
);

    localparam int unsigned NUM_CHUNK   = (WIDTH_INPUT + WIDTH_OUTPUT - 1) / WIDTH_OUTPUT;
    localparam int unsigned WIDTH_COUNT = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
    localparam int unsigned WIDTH_BUF   = NUM_CHUNK * WIDTH_OUTPUT;
    localparam logic [WIDTH_COUNT-1:0] LAST_COUNT = WIDTH_COUNT'(NUM_CHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state;
    logic [WIDTH_COUNT-1:0]  count;
    logic [WIDTH_BUF-1:0]    word_buf;
    logic [WIDTH_OUTPUT-1:0] chunk;
    logic                    busy;
    logic                    accept;
    logic                    advance;

    assign busy    = (state == SEND);
    assign O_Valid = busy;
    assign O_Last  = busy && (count == LAST_COUNT);
    assign O_Ready = !busy || (O_Last && !I_Stall);
    assign accept  = I_Req && O_Ready;
    assign advance = busy && !I_Stall;

    // Chunk select by constant-indexed compare so an unused count value
    // (non-power-of-two NUM_CHUNK) never indexes past the buffer.
    always_comb begin
        chunk = '0;
        for (int unsigned i = 0; i < NUM_CHUNK; i++) begin
            if (count == WIDTH_COUNT'(i)) begin
                chunk = word_buf[i*WIDTH_OUTPUT +: WIDTH_OUTPUT];
            end
        end
    end

    assign O_Data = busy ? chunk : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            word_buf <= '0;
        end else if (accept) begin
            // A new word overrides the end-of-word transition of the previous one.
            word_buf <= WIDTH_BUF'(I_Data);
            count    <= '0;
            state    <= SEND;
        end else if (advance) begin
            if (count == LAST_COUNT) begin
                state <= IDLE;
                count <= '0;
            end else begin
                count <= count + WIDTH_COUNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_ser.sv
// Bench for ser: a 32->8 and a 20->8 instance checked every cycle against a
// chunk-queue model, plus directed literal expectations.
module tb_ser;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req = 1'b0, stall = 1'b0;
    logic [31:0] data = '0;
    logic        ready, valid, last;
    logic [7:0]  odata;

    logic        req2 = 1'b0, stall2 = 1'b0;
    logic [19:0] data2 = '0;
    logic        ready2, valid2, last2;
    logic [7:0]  odata2;

    int unsigned n_pass = 0, n_total = 0;
    bit          started = 1'b0;
    int unsigned q32[$];
    int unsigned q20[$];

    always #5 clock = ~clock;

    ser #(.WIDTH_INPUT(32), .WIDTH_OUTPUT(8)) dut (
        .clock(clock), .reset(reset), .I_Req(req), .I_Data(data),
        .O_Ready(ready), .I_Stall(stall), .O_Valid(valid),
        .O_Data(odata), .O_Last(last)
    );

    ser #(.WIDTH_INPUT(20), .WIDTH_OUTPUT(8)) dut20 (
        .clock(clock), .reset(reset), .I_Req(req2), .I_Data(data2),
        .O_Ready(ready2), .I_Stall(stall2), .O_Valid(valid2),
        .O_Data(odata2), .O_Last(last2)
    );

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: the remaining chunks of the current word, front = chunk on the wire.
    always @(posedge clock) begin
        bit r32, r20;
        r32 = (q32.size() == 0) || (q32.size() == 1 && !stall);
        r20 = (q20.size() == 0) || (q20.size() == 1 && !stall2);
        if (reset) begin
            started = 1'b1;
            q32.delete();
            q20.delete();
        end else begin
            if (req && r32) begin
                q32.delete();
                for (int k = 0; k < 4; k++) q32.push_back((data >> (8*k)) & 32'hFF);
            end else if (q32.size() > 0 && !stall) begin
                void'(q32.pop_front());
            end
            if (req2 && r20) begin
                q20.delete();
                for (int k = 0; k < 3; k++) q20.push_back((32'(data2) >> (8*k)) & 32'hFF);
            end else if (q20.size() > 0 && !stall2) begin
                void'(q20.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        #1;
        if (started) begin
            check("v32", valid, q32.size() > 0);
            check("d32", odata, q32.size() > 0 ? q32[0] : 0);
            check("l32", last, q32.size() == 1);
            check("r32", ready, q32.size() == 0 || (q32.size() == 1 && !stall));
            check("v20", valid2, q20.size() > 0);
            check("d20", odata2, q20.size() > 0 ? q20[0] : 0);
            check("l20", last2, q20.size() == 1);
            check("r20", ready2, q20.size() == 0 || (q20.size() == 1 && !stall2));
        end
    end

    task automatic drive(input logic rq, input logic [31:0] d, input logic st);
        @(negedge clock);
        req = rq; data = d; stall = st;
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [7:0] dt,
                              input logic l, input logic rdy);
        #2;
        check({nm, "_valid"}, valid, v);
        check({nm, "_data"}, odata, dt);
        check({nm, "_last"}, last, l);
        check({nm, "_ready"}, ready, rdy);
    endtask

    initial begin
        logic [7:0] b2b [8];
        bit hold, hold2;
        b2b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        expect_out("reset", 0, 8'h00, 0, 1);

        // single word
        drive(1, 32'hAABBCCDD, 0); expect_out("w1_idle", 0, 8'h00, 0, 1);
        drive(0, 0, 0); expect_out("w1_c0", 1, 8'hDD, 0, 0);
        drive(0, 0, 0); expect_out("w1_c1", 1, 8'hCC, 0, 0);
        drive(0, 0, 0); expect_out("w1_c2", 1, 8'hBB, 0, 0);
        drive(0, 0, 0); expect_out("w1_c3", 1, 8'hAA, 1, 1);
        drive(0, 0, 0); expect_out("w1_done", 0, 8'h00, 0, 1);

        // back-to-back, request held
        drive(1, 32'h11223344, 0); expect_out("b2b_idle", 0, 8'h00, 0, 1);
        for (int k = 0; k < 8; k++) begin
            drive(k < 4, 32'h55667788, 0);
            expect_out("b2b", 1, b2b[k], (k == 3) || (k == 7), (k == 3) || (k == 7));
        end
        drive(0, 0, 0); expect_out("b2b_done", 0, 8'h00, 0, 1);

        // stall on chunk 0xCC
        drive(1, 32'hAABBCCDD, 0); expect_out("st_idle", 0, 8'h00, 0, 1);
        drive(0, 0, 0); expect_out("st_c0", 1, 8'hDD, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 1); expect_out("st_hold", 1, 8'hCC, 0, 0);
        end
        drive(0, 0, 0); expect_out("st_c1", 1, 8'hCC, 0, 0);
        drive(0, 0, 0); expect_out("st_c2", 1, 8'hBB, 0, 0);
        drive(0, 0, 0); expect_out("st_c3", 1, 8'hAA, 1, 1);
        drive(0, 0, 0); expect_out("st_done", 0, 8'h00, 0, 1);

        // reset mid-word
        drive(1, 32'hAABBCCDD, 0);
        drive(0, 0, 0); expect_out("rm_c0", 1, 8'hDD, 0, 0);
        drive(0, 0, 0); reset = 1'b1; expect_out("rm_c1", 1, 8'hCC, 0, 0);
        drive(0, 0, 0); reset = 1'b0; expect_out("rm_after", 0, 8'h00, 0, 1);
        drive(1, 32'h01020304, 0); expect_out("rm_idle", 0, 8'h00, 0, 1);
        drive(0, 0, 0); expect_out("rm_n0", 1, 8'h04, 0, 0);
        drive(0, 0, 0); expect_out("rm_n1", 1, 8'h03, 0, 0);
        drive(0, 0, 0); expect_out("rm_n2", 1, 8'h02, 0, 0);
        drive(0, 0, 0); expect_out("rm_n3", 1, 8'h01, 1, 1);

        // ignored request while busy
        drive(1, 32'hCAFEF00D, 0);
        drive(0, 0, 0); expect_out("ig_c0", 1, 8'h0D, 0, 0);
        drive(1, 32'hDEADBEEF, 0); expect_out("ig_c1", 1, 8'hF0, 0, 0);
        drive(0, 0, 0); expect_out("ig_c2", 1, 8'hFE, 0, 0);
        drive(0, 0, 0); expect_out("ig_c3", 1, 8'hCA, 1, 1);
        drive(0, 0, 0); expect_out("ig_done", 0, 8'h00, 0, 1);

        // non-divisible width 20->8
        @(negedge clock); req2 = 1'b1; data2 = 20'hABCDE;
        @(negedge clock); req2 = 1'b0;
        #2; check("w20_c0", odata2, 8'hDE); check("w20_l0", last2, 0);
        @(negedge clock);
        #2; check("w20_c1", odata2, 8'hBC); check("w20_l1", last2, 0);
        @(negedge clock);
        #2; check("w20_c2", odata2, 8'h0A); check("w20_l2", last2, 1);
        @(negedge clock);
        #2; check("w20_done", valid2, 0);

        // randomized traffic with legal request holding
        hold = 1'b0; hold2 = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 79) == 0);
            if (!hold)  begin req  = ($urandom_range(0, 2) != 0); data  = $urandom; end
            if (!hold2) begin req2 = ($urandom_range(0, 2) != 0); data2 = 20'($urandom); end
            stall  = ($urandom_range(0, 3) == 0);
            stall2 = ($urandom_range(0, 3) == 0);
            #1;
            hold  = req  && !(ready  && !reset);
            hold2 = req2 && !(ready2 && !reset);
        end
        @(negedge clock);
        req = 1'b0; req2 = 1'b0; stall = 1'b0; stall2 = 1'b0; reset = 1'b0;
        repeat (6) @(negedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
